fifo_reader: RTL
================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of FIFO words and stream data.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the transfer counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  permits new FIFO reads while high.
REQ-006 SHALL have port flush  input  1  synchronous discard of all buffered and in-flight words.
REQ-007 SHALL have port empty  input  1  FIFO empty flag.
REQ-008 SHALL have port underflow  input  1  FIFO underflow flag.
REQ-009 SHALL have port data_out  input  DATA_WIDTH  FIFO read data, valid one cycle after an accepted read.
REQ-010 SHALL have port read_en  output  1  FIFO read request.
REQ-011 SHALL have port m_valid  output  1  stream word available.
REQ-012 SHALL have port m_ready  input  1  downstream accepts word.
REQ-013 SHALL have port m_data  output  DATA_WIDTH  stream word.
REQ-014 SHALL have port busy  output  1  high in RUN or DRAIN.
REQ-015 SHALL have port xfer_count  output  CNT_WIDTH  number of stream handshakes completed.
REQ-016 SHALL have port underflow_err  output  1  sticky underflow indication.

Function
REQ-017 SHALL hold a 2-entry in-order output buffer; m_valid = buffer non-empty; m_data = oldest entry.
REQ-018 SHALL track one in-flight flag, set the cycle after read_en=1 with empty=0, and SHALL capture data_out into the buffer on that next cycle.
REQ-019 SHALL assert read_en combinationally only when state=RUN, empty=0, flush=0, and (buffer count + in-flight + 1) <= 2 after accounting for a same-cycle pop.
REQ-020 SHALL never assert read_en while empty=1.
REQ-021 SHALL complete a stream transfer when m_valid=1 and m_ready=1; m_data and m_valid SHALL stay stable while m_valid=1 and m_ready=0.
REQ-022 SHALL support a same-cycle push and pop with the buffer full, keeping order and count.
REQ-023 SHALL implement states IDLE, RUN, DRAIN: IDLE->RUN when enable=1; RUN->DRAIN when enable=0; DRAIN->IDLE when buffer empty and no in-flight; DRAIN->RUN when enable=1.
REQ-024 SHALL, on flush=1, clear the buffer, drop any in-flight word arriving next cycle, deassert read_en and go to IDLE; flush SHALL take priority over enable and m_ready.
REQ-025 SHALL increment xfer_count by 1 per stream transfer, wrapping from 2^CNT_WIDTH-1 to 0; xfer_count SHALL NOT be cleared by flush.
REQ-026 SHALL set underflow_err when underflow=1 and hold it until reset.
REQ-027 SHALL give latency of 2 cycles from read_en acceptance to m_valid (capture cycle + registered buffer).
REQ-028 SHALL sustain one word per cycle when empty=0 and m_ready=1 continuously.

Reset
REQ-029 SHALL, while reset_n=0, force state=IDLE, buffer count=0, in-flight=0, read_en=0, m_valid=0, m_data=0, busy=0, xfer_count=0, underflow_err=0.
REQ-030 SHALL discard any in-flight word when reset is asserted mid-operation.

Verification
REQ-031 Reset, then enable=1, FIFO holds 0x0001..0x0004, m_ready=1 -> m_data 0x0001..0x0004 on 4 consecutive cycles, xfer_count=4.
REQ-032 FIFO holds 3 words, m_ready=0 -> exactly 2 reads issued, m_valid=1, m_data=0x0001 held stable; m_ready=1 -> third word delivered in order.
REQ-033 Stream in progress, enable=0 -> read_en=0 next cycle, buffered words drained, state DRAIN then IDLE, busy=0.
REQ-034 Buffer full plus read in flight, flush=1 -> m_valid=0 next cycle, word arriving after flush dropped, xfer_count unchanged.
REQ-035 underflow pulse 1 cycle -> underflow_err=1 and stays 1 until reset_n=0.
REQ-036 xfer_count preset by 65535 transfers (CNT_WIDTH=16), one more transfer -> xfer_count=0.

Source files
------------

// File: rtl/fifo_reader.sv
// FIFO-to-stream reader: pulls words from a synchronous-read FIFO
// into a 2-entry skid buffer and presents them on a valid/ready stream.
module fifo_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  empty,
    input  logic                  underflow,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  read_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  xfer_count,
    output logic                  underflow_err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] buf0, buf1;
    logic                  rd_ptr, wr_ptr;
    logic [1:0]            count;
    logic                  in_flight;
    logic                  pop, push;
    logic [2:0]            occ;

    assign m_valid = (count != 2'd0);
    assign m_data  = rd_ptr ? buf1 : buf0;
    assign busy    = (state != IDLE);

    assign pop  = m_valid & m_ready & ~flush;
    assign push = in_flight & ~flush;

    // Slots claimed if a read is issued now, net of a same-cycle pop
    assign occ = {1'b0, count} + {2'b00, in_flight} + 3'd1 - {2'b00, pop};

    assign read_en = (state == RUN) & ~empty & ~flush & (occ <= 3'd2);

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (enable) state_nxt = RUN;
                RUN: if (!enable) state_nxt = DRAIN;
                DRAIN: begin
                    if (enable)
                        state_nxt = RUN;
                    else if (count == 2'd0 && !in_flight)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_flight <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_flight <= read_en;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf0   <= '0;
            buf1   <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr) buf1 <= data_out;
                else        buf0 <= data_out;
                wr_ptr <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xfer_count    <= '0;
            underflow_err <= 1'b0;
        end else begin
            if (pop)
                xfer_count <= xfer_count + CNT_WIDTH'(1);
            if (underflow)
                underflow_err <= 1'b1;
        end
    end

endmodule
